// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: FSM states, IR field positions,
// opcode constants and the opcode classifier.
package cpu_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 27;
   localparam int RA_HI  = 26;
   localparam int RA_LO  = 23;
   localparam int RB_HI  = 22;
   localparam int RB_LO  = 19;
   localparam int RC_HI  = 18;
   localparam int RC_LO  = 15;

   localparam logic [4:0] OP_ALU_LAST = 5'b01100;
   localparam logic [4:0] OP_MUL      = 5'b01111;
   localparam logic [4:0] OP_DIV      = 5'b10000;
   localparam logic [4:0] OP_NOP      = 5'b11011;
   localparam logic [4:0] OP_HALT     = 5'b11100;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_MULDIV,
      CL_NOP,
      CL_HALT,
      CL_ILLEGAL
   } op_class_t;

   // Anything outside the defined groups decodes as an illegal nop.
   function automatic op_class_t op_class(input logic [4:0] op);
      if (op <= OP_ALU_LAST)                  return CL_ALU;
      else if (op == OP_MUL || op == OP_DIV)  return CL_MULDIV;
      else if (op == OP_NOP)                  return CL_NOP;
      else if (op == OP_HALT)                 return CL_HALT;
      else                                    return CL_ILLEGAL;
   endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-to-16 one-hot register select with enable; output is all zeros when disabled.
module reg_decoder_4to16 (
   input  logic        en,
   input  logic [3:0]  sel,
   output logic [15:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[sel] = 1'b1;
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), decode (T3), execute (T4-T6),
// plus IDLE and HALT. Outputs depend only on the state register and ir.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   output logic        PCout,
   output logic        MARin,
   output logic        PCin,
   output logic        IncPC,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        ZLowIn,
   output logic        ZHighIn,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic [4:0]  opcode,
   output logic        done,
   output logic        halted,
   output logic        illegal
);

   state_t    state, state_nxt;
   op_class_t cls;
   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       rout_en, rin_en;
   logic [3:0] rout_sel;
   logic       unused_ir;

   assign op        = ir[OPC_HI:OPC_LO];
   assign ra        = ir[RA_HI:RA_LO];
   assign rb        = ir[RB_HI:RB_LO];
   assign rc        = ir[RC_HI:RC_LO];
   assign cls       = op_class(op);
   assign unused_ir = ^ir[RC_LO-1:0];

   always_ff @(posedge clock) begin
      if (!clear) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      PCout = 1'b0;  MARin = 1'b0;  PCin = 1'b0;     IncPC = 1'b0;
      Read = 1'b0;   MDRin = 1'b0;  MDRout = 1'b0;   IRin = 1'b0;
      Yin = 1'b0;    ZLowIn = 1'b0; ZHighIn = 1'b0;  Zlowout = 1'b0;
      Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
      opcode = 5'b00000;
      done = 1'b0;   halted = 1'b0; illegal = 1'b0;
      rout_en = 1'b0; rout_sel = rb; rin_en = 1'b0;
      case (state)
         S_IDLE: if (run) state_nxt = S_T0;
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            Read = 1'b1; MDRin = 1'b1;
            if (mem_rdy) state_nxt = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            case (cls)
               CL_ALU, CL_MULDIV: begin
                  rout_en = 1'b1; Yin = 1'b1;
                  state_nxt = S_T4;
               end
               CL_HALT: state_nxt = S_HALT;
               default: begin
                  done      = 1'b1;
                  illegal   = (cls == CL_ILLEGAL);
                  state_nxt = run ? S_T0 : S_IDLE;
               end
            endcase
         end
         S_T4: begin
            rout_en = 1'b1; rout_sel = rc;
            opcode  = op;
            ZLowIn  = 1'b1;
            ZHighIn = (cls == CL_MULDIV);
            state_nxt = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (cls == CL_MULDIV) begin
               LOin = 1'b1;
               state_nxt = S_T6;
            end else begin
               rin_en = 1'b1; done = 1'b1;
               state_nxt = run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            state_nxt = run ? S_T0 : S_IDLE;
         end
         S_HALT: halted = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

   reg_decoder_4to16 u_rout_dec (.en(rout_en), .sel(rout_sel), .onehot(Rout));
   reg_decoder_4to16 u_rin_dec  (.en(rin_en),  .sel(ra),       .onehot(Rin));

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: constant-expectation table, hand-written corner
// sequences and randomized instructions checked against a per-instruction model.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear, run, mem_rdy;
   logic [31:0] ir;
   logic PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin;
   logic ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin;
   logic [15:0] Rout, Rin;
   logic [4:0]  opcode;
   logic        done, halted, illegal;

   control_unit dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
      .PCout(PCout), .MARin(MARin), .PCin(PCin), .IncPC(IncPC), .Read(Read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin), .opcode(opcode),
      .done(done), .halted(halted), .illegal(illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic pcout, marin, pcin, incpc, read, mdrin, mdrout, irin, yin;
      logic zlowin, zhighin, zlowout, zhighout, hiin, loin;
      logic [15:0] rout, rin;
      logic [4:0]  op;
      logic done, halted, illegal;
   } outs_t;

   typedef struct {
      logic [31:0] ir;
      int          w;
      int          cycles;
      logic [15:0] rout3, rout4, rin;
      logic        ill;
   } vec_t;

   outs_t act;
   assign act = {PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin,
                 ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin,
                 Rout, Rin, opcode, done, halted, illegal};

   int  n_cmp = 0, n_bad = 0;
   bit  in_idle;

   task automatic cmp(input string name, input longint a, input longint e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   task automatic tick(input outs_t e, input string name);
      @(negedge clock);
      n_cmp++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, e);
      end
      @(posedge clock); #1;
   endtask

   // Expected per-cycle outputs of one instruction, derived from the opcode
   // groups and the T0..T6 step descriptions.
   task automatic exec(input logic [31:0] i_ir, input int w, input bit run_after,
                       input int abort_at, input string name);
      outs_t q[$];
      outs_t r;
      logic [4:0] op;
      int  ra, rb, rc;
      bit  alu, md, aborted;
      op = i_ir[31:27]; ra = int'(i_ir[26:23]); rb = int'(i_ir[22:19]); rc = int'(i_ir[18:15]);
      alu = (op <= 5'd12);
      md  = (op == 5'd15) || (op == 5'd16);
      r = '0; r.pcout = 1; r.marin = 1; r.pcin = 1; r.incpc = 1; q.push_back(r);
      for (int k = 0; k <= w; k++) begin
         r = '0; r.read = 1; r.mdrin = 1; q.push_back(r);
      end
      r = '0; r.mdrout = 1; r.irin = 1; q.push_back(r);
      r = '0;
      if (alu || md) begin
         r.rout = 16'(1) << rb; r.yin = 1; q.push_back(r);
         r = '0; r.rout = 16'(1) << rc; r.op = op; r.zlowin = 1; r.zhighin = md; q.push_back(r);
         r = '0; r.zlowout = 1;
         if (md) begin
            r.loin = 1; q.push_back(r);
            r = '0; r.zhighout = 1; r.hiin = 1; r.done = 1; q.push_back(r);
         end else begin
            r.rin = 16'(1) << ra; r.done = 1; q.push_back(r);
         end
      end else if (op == 5'd28) begin
         q.push_back(r);
      end else begin
         r.done = 1; r.illegal = (op != 5'd27); q.push_back(r);
      end

      if (in_idle) begin
         run = 1; mem_rdy = 1'($urandom_range(0, 1));
         tick('0, {name, "_idle"});
         in_idle = 0;
      end
      ir = i_ir;
      aborted = 0;
      for (int c = 0; c < q.size() && !aborted; c++) begin
         run     = (c == q.size() - 1) ? run_after : 1'($urandom_range(0, 1));
         mem_rdy = (c >= 1 && c <= 1 + w) ? (c == 1 + w) : 1'($urandom_range(0, 1));
         clear   = (c == abort_at) ? 1'b0 : 1'b1;
         tick(q[c], $sformatf("%s_c%0d", name, c));
         if (c == abort_at) begin
            clear = 1; run = 0;
            tick('0, {name, "_after_clear"});
            in_idle = 1; aborted = 1;
         end
      end
      if (aborted) return;
      if (op == 5'd28) begin
         r = '0; r.halted = 1;
         for (int k = 0; k < 20; k++) begin
            run = 1'($urandom_range(0, 1)); mem_rdy = 1'($urandom_range(0, 1));
            tick(r, $sformatf("%s_halt%0d", name, k));
         end
         clear = 0;
         tick(r, {name, "_halt_clr"});
         clear = 1; run = 0;
         tick('0, {name, "_halt_exit"});
         in_idle = 1;
      end else begin
         in_idle = !run_after;
      end
   endtask

   initial begin
      vec_t vt[$];
      int  done_cyc, reads;
      logic [15:0] r3, r4, rin_or;
      logic ill_or;
      logic [4:0] op;
      logic [31:0] rir;

      clear = 0; run = 0; mem_rdy = 0; ir = '0;
      repeat (2) @(posedge clock);
      #1;
      clear = 1;
      tick('0, "reset_state");
      in_idle = 1;

      vt.push_back('{32'h5A1B8000, 0, 6, 16'h0008, 16'h0080, 16'h0010, 1'b0});
      vt.push_back('{32'h5A1B8000, 3, 9, 16'h0008, 16'h0080, 16'h0010, 1'b0});
      vt.push_back('{32'h78928000, 0, 7, 16'h0004, 16'h0020, 16'h0000, 1'b0});
      vt.push_back('{32'h80000000, 1, 8, 16'h0001, 16'h0001, 16'h0000, 1'b0});
      vt.push_back('{32'hD8000000, 0, 4, 16'h0000, 16'h0000, 16'h0000, 1'b0});
      vt.push_back('{32'hF8000000, 1, 5, 16'h0000, 16'h0000, 16'h0000, 1'b1});
      vt.push_back('{32'h07878000, 0, 6, 16'h0001, 16'h8000, 16'h8000, 1'b0});
      vt.push_back('{32'h60498000, 2, 8, 16'h0200, 16'h0008, 16'h0001, 1'b0});
      vt.push_back('{32'h68000000, 0, 4, 16'h0000, 16'h0000, 16'h0000, 1'b1});

      foreach (vt[i]) begin
         ir = vt[i].ir; run = 1; mem_rdy = 1;
         @(posedge clock); #1;
         run = 0;
         done_cyc = 0; reads = 0; r3 = '0; r4 = '0; rin_or = '0; ill_or = 0;
         for (int c = 1; c <= 15 && done_cyc == 0; c++) begin
            mem_rdy = !(c >= 2 && c < 2 + vt[i].w);
            @(negedge clock);
            if (c == vt[i].w + 4) r3 = Rout;
            if (c == vt[i].w + 5) r4 = Rout;
            rin_or |= Rin;
            ill_or |= illegal;
            reads  += int'(Read);
            if (done) done_cyc = c;
            @(posedge clock); #1;
         end
         cmp($sformatf("vec%0d_cycles", i),  done_cyc, vt[i].cycles);
         cmp($sformatf("vec%0d_rout_t3", i), r3,       vt[i].rout3);
         cmp($sformatf("vec%0d_rout_t4", i), r4,       vt[i].rout4);
         cmp($sformatf("vec%0d_rin", i),     rin_or,   vt[i].rin);
         cmp($sformatf("vec%0d_illegal", i), ill_or,   vt[i].ill);
         cmp($sformatf("vec%0d_reads", i),   reads,    vt[i].w + 1);
         tick('0, $sformatf("vec%0d_back_idle", i));
      end

      exec(32'h5A1B8000, 0, 1, -1, "shl");
      exec(32'h5A1B8000, 3, 0, -1, "shl_wait");
      exec(32'h78928000, 0, 1, -1, "mul");
      exec(32'h5A1B8000, 0, 1, 4, "clr_t4");
      exec(32'h5A1B8000, 3, 1, 2, "clr_t1");
      exec(32'h78928000, 1, 1, 5, "clr_t5");
      exec(32'hF8000000, 0, 1, -1, "illegal");
      exec(32'hD8000000, 2, 0, -1, "nop");
      exec(32'hE0000000, 0, 1, -1, "halt");

      for (int n = 0; n < 80; n++) begin
         rir = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
               0:       op = 5'($urandom_range(0, 12));
               1:       op = 5'd15;
               2:       op = 5'd16;
               default: op = 5'($urandom_range(0, 31));
            endcase
            rir[31:27] = op;
         end
         exec(rir, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1,
              $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 clear  in  1  synchronous, active-low reset.
REQ-003 run  in  1  start/continue; sampled only in IDLE and at instruction boundaries.
REQ-004 ir  in  32  IR register contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005 mem_rdy  in  1  memory read-data valid; completes the Read handshake.
REQ-006 PCout, MARin, PCin, IncPC, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
REQ-007 ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
REQ-008 Rout  out  16  one-hot register-to-bus select (bit n = Rn).
REQ-009 Rin  out  16  one-hot bus-to-register write enable.
REQ-010 opcode  out  5  ALU operation select.
REQ-011 done  out  1  one-cycle pulse in the last cycle of each completed instruction.
REQ-012 halted  out  1  high while in HALT.
REQ-013 illegal  out  1  one-cycle pulse in T3 for an undefined opcode.

Function
REQ-014 FSM states SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT.
REQ-015 Outputs SHALL be a pure function of the registered state and ir (Moore plus field decode); every strobe defaults to 0 and opcode defaults to 00000.
REQ-016 IDLE: all strobes 0; run=1 -> T0, otherwise stay.
REQ-017 T0: PCout, MARin, IncPC, PCin = 1; -> T1.
REQ-018 T1: Read, MDRin = 1; stay while mem_rdy=0; mem_rdy=1 -> T2.
REQ-019 T2: MDRout, IRin = 1; -> T3.
REQ-020 T3 decode: class A opcodes 00000-01100 and mul/div (01111/10000): Rout=onehot(Rb), Yin=1, -> T4.
REQ-021 T3 nop 11011: no strobes, done=1, -> T0 or IDLE per REQ-026.
REQ-022 T3 halt 11100: -> HALT.
REQ-023 T3 any other opcode: treated as nop and illegal=1.
REQ-024 T4: Rout=onehot(Rc), opcode=ir[31:27], ZLowIn=1; ZHighIn=1 additionally for mul/div; -> T5.
REQ-025 T5 class A: Zlowout=1, Rin=onehot(Ra), done=1. T5 mul/div: Zlowout=1, LOin=1, -> T6. T6: Zhighout=1, HIin=1, done=1.
REQ-026 At an instruction boundary: run=1 -> T0, run=0 -> IDLE; a run deassertion mid-instruction SHALL never abort the instruction.
REQ-027 Latency with mem_rdy tied high: class A 6 cycles, mul/div 7 cycles, nop 4 cycles (T0..last state inclusive); each mem_rdy=0 cycle in T1 adds one cycle.
REQ-028 Rout and Rin SHALL never have more than one bit set; Ra=Rb=Rc is legal, and R0 is writable.
REQ-029 HALT: all strobes 0, halted=1; exited only by clear.

Reset
REQ-030 clear=0 at a rising edge SHALL force IDLE on that edge from any state, including mid-handshake in T1 and during T4/T5, so that every output is 0 (opcode 00000, done/halted/illegal 0) in the following cycle.
REQ-031 A register write (Rin) SHALL NOT be issued in the cycle following a reset edge.

Structure
REQ-032 Opcode constants, IR field bit positions and the state encoding SHALL reside in the shared package cpu_pkg.
REQ-033 The 4-to-16 one-hot decode SHALL be a sub-module reg_decoder_4to16, instantiated once for Rout and once for Rin.

Verification
REQ-034 run=1, mem_rdy=1, ir=0x5A1B8000 (shl R4,R3,R7) -> T3 Rout=0x0008 with Yin; T4 Rout=0x0080, opcode=01011, ZLowIn; T5 Zlowout, Rin=0x0010, done; 6 cycles total.
REQ-035 Same instruction with mem_rdy low for 3 cycles in T1 -> Read and MDRin high for 4 cycles; done on cycle 9.
REQ-036 ir opcode 01111, Rb=R2, Rc=R5 -> T4 Rout=0x0020 with ZLowIn and ZHighIn; T5 Zlowout with LOin; T6 Zhighout with HIin and done; Rin=0 throughout.
REQ-037 ir=0xE0000000 (halt) -> halted=1 from the cycle after T3; all strobes 0 for 20 cycles; clear=0 -> IDLE, halted=0.
REQ-038 clear=0 asserted during T4 -> the next cycle is IDLE with all outputs 0, and no Rin pulse occurs.
REQ-039 run dropped in T2 of a class A instruction -> the instruction completes with done, then IDLE; ir opcode 11111 -> illegal pulse in T3, followed by nop behaviour.
